ahb_slave_arb_ctrl: RTL and testbench
=====================================

Name: ahb_slave_arb_ctrl

Overview:
- Sequential per-slave arbiter controller for the AHB_Gen interconnect.
- Selects one of REQ_NUM masters for a single slave port:
  - highest dynamic priority level wins;
  - round-robin breaks ties within that level.
- Holds the grant for a whole burst by counting accepted beats against the HBURST length.
- Generates hlast and re-arbitrates on burst completion or early release.

Parameters:
- REQ_NUM, 8, number of requesting masters (2..16)
- PRIOR_BIT, 2, width of each master's priority field
- UNDL_LIMIT, 4, beat limit for INCR (undefined-length) bursts before forced re-arbitration (1..16)

Ports:
- hclk  in  1  clock, rising edge
- hreset_n  in  1  asynchronous active-low reset
- hreq  in  REQ_NUM  per-master request
- hprior  in  REQ_NUM x PRIOR_BIT  per-master priority; larger value = higher priority
- hburst  in  REQ_NUM x 3  per-master HBURST (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7)
- htrans  in  REQ_NUM x 2  per-master HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- hready  in  1  slave ready, beat accept qualifier
- hgrant  out  REQ_NUM  one-hot registered grant
- hmaster  out  $clog2(REQ_NUM)  index of granted master, valid when busy=1
- busy  out  1  a grant is active (state OWN)
- hlast  out  1  current beat is the final beat of the granted burst

Behaviour:
- Reset (async, hreset_n=0):
  - state=IDLE; hgrant=0; hmaster=0; busy=0; hlast=0.
  - Beat count=0; latched length=1; round-robin pointer=REQ_NUM-1, so master 0 wins the first tie.
- Arbitration function (combinational, evaluated every cycle):
  - Level L = max hprior over masters with hreq=1.
  - Winner = first requesting master at level L, scanning upward circularly from pointer+1.
  - No requests -> no winner.
- States:
  - IDLE: if a winner exists, next edge enters OWN with hgrant=onehot(winner), hmaster=winner, count=0, pointer=winner. Otherwise stay.
  - OWN: grant frozen; changes on other masters' hreq/hprior are ignored until release.
- Accepted beat: state OWN and hready=1 and htrans[hmaster] in {NONSEQ, SEQ}. BUSY and IDLE beats are not counted.
- Burst length:
  - Decode: SINGLE=1, INCR=UNDL_LIMIT, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16.
  - Latched from hburst[hmaster] on an accepted NONSEQ beat.
  - While count=0, the effective length is decoded from the live hburst[hmaster].
  - A NONSEQ beat always restarts the count: count becomes 1.
- Count rules:
  - Increments by 1 per accepted beat.
  - Width is 5 bits, so no wrap is possible because release occurs at length.
- hlast:
  - Combinational: hlast = busy & (count == eff_len-1) & htrans[hmaster] in {NONSEQ, SEQ}.
  - For SINGLE, hlast is high on the NONSEQ beat itself.
- Release from OWN happens on a rising edge when either of these holds:
  - (a) an accepted beat occurs with hlast=1;
  - (b) hready=1 and htrans[hmaster]=IDLE and hreq[hmaster]=0, i.e. early termination / INCR stop.
- Handover on release:
  - If a winner exists that cycle, go directly to OWN with the new grant in the same edge. No dead cycle; the winner may be the same master, with rotation via the pointer.
  - Otherwise go to IDLE with hgrant=0.
- hready=0 freezes the count and state. A release condition is honoured only with hready=1.
- Reset mid-burst: all state clears immediately and asynchronously; the grant drops the same instant.
- Simultaneous requests at equal priority are served in round-robin order across successive bursts. Starvation of lower levels is accepted by design.

Test Plan:
- Masters 2 and 5 request, hprior=1 and 3 -> after 1 edge hgrant=0x20, hmaster=5, busy=1.
- Master 3 INCR4, hready always 1, NONSEQ then 3×SEQ -> hlast high on the 4th beat only. At that edge the grant moves to pending master 1 (hgrant 0x08 -> 0x02) with no idle cycle.
- Masters 0, 1, 2 all hprior=2, SINGLE bursts, continuous requests -> grant sequence 0,1,2,0; each held exactly one accepted beat.
- INCR8 with hready low for 3 cycles mid-burst, plus one BUSY beat -> count stalls. hlast asserts on the 8th accepted beat and the grant is held throughout.
- Master 4 INCR, drops hreq and drives htrans=IDLE after 2 beats with hready=1 -> next edge hgrant=0, busy=0, state IDLE. A further INCR without stop is released after UNDL_LIMIT=4 beats.
- Assert hreset_n=0 mid-WRAP16 at count 7 -> hgrant=0, busy=0, hlast=0 immediately. After release from reset, master 0 wins a tie against master 1.

Source files
------------

// File: rtl/ahb_slave_arb_ctrl.sv
// Per-slave AHB arbiter: priority-then-round-robin selection, grant held for a
// whole burst by counting accepted beats, with hlast and early-release handover.
module ahb_slave_arb_ctrl #(
   parameter int unsigned REQ_NUM    = 8,
   parameter int unsigned PRIOR_BIT  = 2,
   parameter int unsigned UNDL_LIMIT = 4
) (
   input  logic                         hclk,
   input  logic                         hreset_n,
   input  logic [REQ_NUM-1:0]           hreq,
   input  logic [REQ_NUM*PRIOR_BIT-1:0] hprior,
   input  logic [REQ_NUM*3-1:0]         hburst,
   input  logic [REQ_NUM*2-1:0]         htrans,
   input  logic                         hready,
   output logic [REQ_NUM-1:0]           hgrant,
   output logic [$clog2(REQ_NUM)-1:0]   hmaster,
   output logic                         busy,
   output logic                         hlast
);

   localparam int unsigned MW = $clog2(REQ_NUM);

   typedef enum logic {IDLE, OWN} state_t;

   state_t               state, state_nx;
   logic [REQ_NUM-1:0]   grant_nx;
   logic [MW-1:0]        master_nx, ptr, ptr_nx;
   logic [4:0]           count, count_nx, len_q, len_nx, eff_len;
   logic [PRIOR_BIT-1:0] top_lvl;
   logic                 any_req, win_vld;
   logic [MW-1:0]        win;
   logic [1:0]           cur_trans;
   logic [2:0]           cur_burst;
   logic                 cur_active, beat_ok, rel;

   function automatic logic [4:0] burst_len(input logic [2:0] b);
      case (b)
         3'd0:       return 5'd1;
         3'd1:       return 5'(UNDL_LIMIT);
         3'd2, 3'd3: return 5'd4;
         3'd4, 3'd5: return 5'd8;
         default:    return 5'd16;
      endcase
   endfunction

   // Two passes: find the highest requested level, then scan circularly from ptr+1.
   always_comb begin
      int unsigned idx;
      logic [MW-1:0] sel;
      top_lvl = '0;
      any_req = 1'b0;
      win     = '0;
      win_vld = 1'b0;
      idx     = 0;
      sel     = '0;
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
         if (hreq[i] && (!any_req || hprior[i*PRIOR_BIT +: PRIOR_BIT] > top_lvl)) begin
            top_lvl = hprior[i*PRIOR_BIT +: PRIOR_BIT];
            any_req = 1'b1;
         end
      end
      for (int unsigned k = 1; k <= REQ_NUM; k++) begin
         idx = (32'(ptr) + k) % REQ_NUM;
         sel = MW'(idx);
         if (!win_vld && hreq[sel] && hprior[sel*PRIOR_BIT +: PRIOR_BIT] == top_lvl) begin
            win     = sel;
            win_vld = 1'b1;
         end
      end
   end

   assign cur_trans  = htrans[hmaster*2 +: 2];
   assign cur_burst  = hburst[hmaster*3 +: 3];
   assign cur_active = cur_trans[1];
   assign busy       = (state == OWN);
   assign eff_len    = (count == 5'd0) ? burst_len(cur_burst) : len_q;
   assign hlast      = busy && (count == eff_len - 5'd1) && cur_active;
   assign beat_ok    = busy && hready && cur_active;
   assign rel        = (beat_ok && hlast) ||
                       (busy && hready && cur_trans == 2'b00 && !hreq[hmaster]);

   always_comb begin
      state_nx  = state;
      grant_nx  = hgrant;
      master_nx = hmaster;
      count_nx  = count;
      len_nx    = len_q;
      ptr_nx    = ptr;
      case (state)
         IDLE: begin
            if (win_vld) begin
               state_nx      = OWN;
               grant_nx      = '0;
               grant_nx[win] = 1'b1;
               master_nx     = win;
               count_nx      = '0;
               ptr_nx        = win;
            end
         end
         OWN: begin
            if (beat_ok) begin
               if (cur_trans == 2'b10) begin
                  count_nx = 5'd1;
                  len_nx   = burst_len(cur_burst);
               end else begin
                  count_nx = count + 5'd1;
               end
            end
            // Release hands over in the same edge when someone is waiting.
            if (rel) begin
               count_nx = '0;
               if (win_vld) begin
                  state_nx      = OWN;
                  grant_nx      = '0;
                  grant_nx[win] = 1'b1;
                  master_nx     = win;
                  ptr_nx        = win;
               end else begin
                  state_nx = IDLE;
                  grant_nx = '0;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state   <= IDLE;
         hgrant  <= '0;
         hmaster <= '0;
         count   <= '0;
         len_q   <= 5'd1;
         ptr     <= MW'(REQ_NUM - 1);
      end else begin
         state   <= state_nx;
         hgrant  <= grant_nx;
         hmaster <= master_nx;
         count   <= count_nx;
         len_q   <= len_nx;
         ptr     <= ptr_nx;
      end
   end

endmodule

// File: tb/tb_ahb_slave_arb_ctrl.sv
// Directed bench for ahb_slave_arb_ctrl: priority, handover, round-robin,
// stalls, early release, UNDL limit and asynchronous reset mid-burst.
module tb_ahb_slave_arb_ctrl;

   logic        hclk, hreset_n;
   logic [7:0]  hreq;
   logic [15:0] hprior;
   logic [23:0] hburst;
   logic [15:0] htrans;
   logic        hready;
   logic [7:0]  hgrant;
   logic [2:0]  hmaster;
   logic        busy, hlast;

   int errors = 0;
   int checks = 0;

   localparam bit [1:0] ST_TR  [13] = '{2, 3, 3, 3, 3, 3, 1, 3, 3, 3, 3, 3, 3};
   localparam bit       ST_RDY [13] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 1};
   localparam bit       ST_LST [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
   localparam int       RR_SEQ [4]  = '{0, 1, 2, 0};

   ahb_slave_arb_ctrl #(.REQ_NUM(8), .PRIOR_BIT(2), .UNDL_LIMIT(4)) dut (
      .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hprior(hprior),
      .hburst(hburst), .htrans(htrans), .hready(hready), .hgrant(hgrant),
      .hmaster(hmaster), .busy(busy), .hlast(hlast)
   );

   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge hclk);
      @(negedge hclk);
   endtask

   task automatic set_m(input int m, input logic [1:0] pr, input logic [2:0] bu, input logic [1:0] tr);
      hprior[m*2 +: 2] = pr;
      hburst[m*3 +: 3] = bu;
      htrans[m*2 +: 2] = tr;
   endtask

   task automatic cleanup();
      hreq   = '0;
      htrans = '0;
      hready = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_reset();
      hreset_n = 1'b0;
      hreq = '0; hprior = '0; hburst = '0; htrans = '0; hready = 1'b1;
      tick();
      #1;
      checks++; if (hgrant !== 8'h00) begin errors++; $display("FAIL reset_hgrant: got %h expected 00", hgrant); end
      checks++; if (hmaster !== 3'd0) begin errors++; $display("FAIL reset_hmaster: got %0d expected 0", hmaster); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (hlast !== 1'b0) begin errors++; $display("FAIL reset_hlast: got %b expected 0", hlast); end
      hreset_n = 1'b1;
      tick();
   endtask

   task automatic test_priority();
      hprior = '0; hburst = '0; htrans = '0; hready = 1'b1;
      set_m(2, 2'd1, 3'd0, 2'd0);
      set_m(5, 2'd3, 3'd0, 2'd0);
      hreq = 8'b0010_0100;
      tick();
      #1;
      checks++; if (hgrant !== 8'h20) begin errors++; $display("FAIL prio_hgrant: got %h expected 20", hgrant); end
      checks++; if (hmaster !== 3'd5) begin errors++; $display("FAIL prio_hmaster: got %0d expected 5", hmaster); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prio_busy: got %b expected 1", busy); end
      cleanup();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_release_busy: got %b expected 0", busy); end
   endtask

   task automatic test_handover();
      hprior = '0; hburst = '0; htrans = '0; hready = 1'b1;
      set_m(3, 2'd1, 3'd3, 2'd0);
      hreq = 8'h08;
      tick();
      #1;
      checks++; if (hgrant !== 8'h08) begin errors++; $display("FAIL ho_grant3: got %h expected 08", hgrant); end
      set_m(1, 2'd1, 3'd0, 2'd0);
      hreq = 8'h0A;
      for (int b = 0; b < 4; b++) begin
         htrans[3*2 +: 2] = (b == 0) ? 2'd2 : 2'd3;
         if (b == 3) hreq[3] = 1'b0;
         #1;
         checks++; if (hlast !== (b == 3)) begin errors++; $display("FAIL ho_hlast beat %0d: got %b expected %b", b, hlast, (b == 3)); end
         checks++; if (hgrant !== 8'h08) begin errors++; $display("FAIL ho_hold beat %0d: got %h expected 08", b, hgrant); end
         tick();
      end
      #1;
      checks++; if (hgrant !== 8'h02) begin errors++; $display("FAIL ho_new_grant: got %h expected 02", hgrant); end
      checks++; if (hmaster !== 3'd1) begin errors++; $display("FAIL ho_new_master: got %0d expected 1", hmaster); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ho_no_idle: got %b expected 1", busy); end
      cleanup();
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_g;
      hreset_n = 1'b0;
      #1;
      hreset_n = 1'b1;
      hprior = '0; hburst = '0; htrans = '0; hready = 1'b1;
      for (int m = 0; m < 3; m++) set_m(m, 2'd2, 3'd0, 2'd2);
      hreq = 8'h07;
      for (int k = 0; k < 4; k++) begin
         tick();
         #1;
         exp_g = 8'h01 << RR_SEQ[k];
         checks++; if (hgrant !== exp_g) begin errors++; $display("FAIL rr_grant step %0d: got %h expected %h", k, hgrant, exp_g); end
         checks++; if (hlast !== 1'b1) begin errors++; $display("FAIL rr_hlast step %0d: got %b expected 1", k, hlast); end
      end
      cleanup();
   endtask

   task automatic test_stall();
      hprior = '0; hburst = '0; htrans = '0; hready = 1'b1;
      set_m(6, 2'd0, 3'd5, 2'd0);
      hreq = 8'h40;
      tick();
      #1;
      checks++; if (hgrant !== 8'h40) begin errors++; $display("FAIL st_grant: got %h expected 40", hgrant); end
      for (int i = 0; i < 13; i++) begin
         htrans[6*2 +: 2] = ST_TR[i];
         hready = ST_RDY[i];
         if (i == 12) hreq = '0;
         #1;
         checks++; if (hlast !== ST_LST[i]) begin errors++; $display("FAIL st_hlast cycle %0d: got %b expected %b", i, hlast, ST_LST[i]); end
         checks++; if (hgrant !== 8'h40) begin errors++; $display("FAIL st_hold cycle %0d: got %h expected 40", i, hgrant); end
         tick();
      end
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL st_release: got %b expected 0", busy); end
      cleanup();
   endtask

   task automatic test_early_release();
      hprior = '0; hburst = '0; htrans = '0; hready = 1'b1;
      set_m(4, 2'd1, 3'd1, 2'd0);
      hreq = 8'h10;
      tick();
      #1;
      checks++; if (hgrant !== 8'h10) begin errors++; $display("FAIL er_grant: got %h expected 10", hgrant); end
      for (int b = 0; b < 2; b++) begin
         htrans[4*2 +: 2] = (b == 0) ? 2'd2 : 2'd3;
         #1;
         checks++; if (hlast !== 1'b0) begin errors++; $display("FAIL er_hlast beat %0d: got %b expected 0", b, hlast); end
         tick();
      end
      hreq = '0;
      htrans[4*2 +: 2] = 2'd0;
      tick();
      #1;
      checks++; if (hgrant !== 8'h00) begin errors++; $display("FAIL er_hgrant: got %h expected 00", hgrant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL er_busy: got %b expected 0", busy); end
      hreq = 8'h10;
      tick();
      for (int b = 0; b < 4; b++) begin
         htrans[4*2 +: 2] = (b == 0) ? 2'd2 : 2'd3;
         if (b == 3) hreq = '0;
         #1;
         checks++; if (hlast !== (b == 3)) begin errors++; $display("FAIL undl_hlast beat %0d: got %b expected %b", b, hlast, (b == 3)); end
         tick();
      end
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL undl_release: got %b expected 0", busy); end
      cleanup();
   endtask

   task automatic test_reset_mid();
      hprior = '0; hburst = '0; htrans = '0; hready = 1'b1;
      set_m(2, 2'd0, 3'd6, 2'd0);
      hreq = 8'h04;
      tick();
      for (int b = 0; b < 7; b++) begin
         htrans[2*2 +: 2] = (b == 0) ? 2'd2 : 2'd3;
         tick();
      end
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_pre: got %b expected 1", busy); end
      checks++; if (hlast !== 1'b0) begin errors++; $display("FAIL rm_hlast_pre: got %b expected 0", hlast); end
      hreset_n = 1'b0;
      #1;
      checks++; if (hgrant !== 8'h00) begin errors++; $display("FAIL rm_hgrant: got %h expected 00", hgrant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", busy); end
      checks++; if (hlast !== 1'b0) begin errors++; $display("FAIL rm_hlast: got %b expected 0", hlast); end
      htrans = '0;
      hprior = '0;
      hreq = 8'h03;
      hreset_n = 1'b1;
      tick();
      #1;
      checks++; if (hgrant !== 8'h01) begin errors++; $display("FAIL rm_tie_grant: got %h expected 01", hgrant); end
      checks++; if (hmaster !== 3'd0) begin errors++; $display("FAIL rm_tie_master: got %0d expected 0", hmaster); end
      cleanup();
   endtask

   initial begin
      test_reset();
      test_priority();
      test_handover();
      test_round_robin();
      test_stall();
      test_early_release();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
